// File: rtl/riscv_wb_arbiter_if.sv
// Write-back bus between the ALU/MUL/LSU result producers, the arbiter and the
// register-file write ports.
interface riscv_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  alu_valid_i, mul_valid_i, lsu_valid_i;
  logic [ADDR_WIDTH-1:0] alu_waddr_i, mul_waddr_i, lsu_waddr_i;
  logic [DATA_WIDTH-1:0] alu_wdata_i, mul_wdata_i, lsu_wdata_i;
  logic                  alu_ready_o, mul_ready_o, lsu_ready_o;
  logic [ADDR_WIDTH-1:0] waddr_a_o, waddr_b_o;
  logic [DATA_WIDTH-1:0] wdata_a_o, wdata_b_o;
  logic                  we_a_o, we_b_o;
  logic                  mul_starved_o;

  modport slave (
    input  alu_valid_i, mul_valid_i, lsu_valid_i,
    input  alu_waddr_i, mul_waddr_i, lsu_waddr_i,
    input  alu_wdata_i, mul_wdata_i, lsu_wdata_i,
    output alu_ready_o, mul_ready_o, lsu_ready_o,
    output waddr_a_o, wdata_a_o, we_a_o,
    output waddr_b_o, wdata_b_o, we_b_o,
    output mul_starved_o
  );

  modport master (
    output alu_valid_i, mul_valid_i, lsu_valid_i,
    output alu_waddr_i, mul_waddr_i, lsu_waddr_i,
    output alu_wdata_i, mul_wdata_i, lsu_wdata_i,
    input  alu_ready_o, mul_ready_o, lsu_ready_o,
    input  waddr_a_o, wdata_a_o, we_a_o,
    input  waddr_b_o, wdata_b_o, we_b_o,
    input  mul_starved_o
  );
endinterface

// File: rtl/riscv_wb_arbiter.sv
// Two-port register-file write-back arbiter for ALU, MUL and LSU results.
// LSU owns port B; MUL gains port A after STARVE_LIMIT consecutive stalls.
module riscv_wb_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  riscv_wb_arbiter_if.slave bus
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_MUL, SRC_LSU} src_e;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  starved;
  logic                  alu_rdy, mul_rdy, lsu_rdy;
  logic                  alu_gnt, mul_gnt, lsu_gnt;
  logic                  mul_on_a, alu_on_a, starved_mode;
  logic                  lsu_mul_conf, lsu_alu_conf, mul_alu_same;
  src_e                  src_a, src_b;
  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;
  logic                  we_a_q, we_a_d, we_b_q, we_b_d;

  assign starved = (cnt_q >= LIMIT);

  // Each ready is evaluated assuming its own producer is valid, so no
  // producer's ready ever depends on its own valid.
  always_comb begin
    lsu_mul_conf = bus.lsu_valid_i && (|bus.lsu_waddr_i) && (bus.lsu_waddr_i == bus.mul_waddr_i);
    lsu_alu_conf = bus.lsu_valid_i && (|bus.lsu_waddr_i) && (bus.lsu_waddr_i == bus.alu_waddr_i);
    mul_alu_same = (|bus.alu_waddr_i) && (bus.alu_waddr_i == bus.mul_waddr_i);
    starved_mode = starved && bus.mul_valid_i;

    lsu_rdy = !rst;
    mul_rdy = !rst && (starved || !bus.alu_valid_i || !bus.lsu_valid_i) && !lsu_mul_conf;
    if (starved_mode)
      alu_rdy = !rst && !bus.lsu_valid_i && !mul_alu_same;
    else
      alu_rdy = !rst && !lsu_alu_conf && !(bus.mul_valid_i && !bus.lsu_valid_i && mul_alu_same);

    alu_gnt  = bus.alu_valid_i && alu_rdy;
    mul_gnt  = bus.mul_valid_i && mul_rdy;
    lsu_gnt  = bus.lsu_valid_i && lsu_rdy;
    mul_on_a = starved || !bus.alu_valid_i;
    alu_on_a = !starved_mode;

    src_a = SRC_NONE;
    if (mul_gnt && mul_on_a)      src_a = SRC_MUL;
    else if (alu_gnt && alu_on_a) src_a = SRC_ALU;

    src_b = SRC_NONE;
    if (lsu_gnt)                   src_b = SRC_LSU;
    else if (mul_gnt && !mul_on_a) src_b = SRC_MUL;
    else if (alu_gnt && !alu_on_a) src_b = SRC_ALU;
  end

  // Address/data follow the granted source; an x0 write updates them but keeps we low.
  always_comb begin
    waddr_a_d = waddr_a_q;
    wdata_a_d = wdata_a_q;
    we_a_d    = 1'b0;
    unique case (src_a)
      SRC_ALU: begin waddr_a_d = bus.alu_waddr_i; wdata_a_d = bus.alu_wdata_i; end
      SRC_MUL: begin waddr_a_d = bus.mul_waddr_i; wdata_a_d = bus.mul_wdata_i; end
      default: ;
    endcase
    if (src_a != SRC_NONE) we_a_d = |waddr_a_d;

    waddr_b_d = waddr_b_q;
    wdata_b_d = wdata_b_q;
    we_b_d    = 1'b0;
    unique case (src_b)
      SRC_ALU: begin waddr_b_d = bus.alu_waddr_i; wdata_b_d = bus.alu_wdata_i; end
      SRC_MUL: begin waddr_b_d = bus.mul_waddr_i; wdata_b_d = bus.mul_wdata_i; end
      SRC_LSU: begin waddr_b_d = bus.lsu_waddr_i; wdata_b_d = bus.lsu_wdata_i; end
      default: ;
    endcase
    if (src_b != SRC_NONE) we_b_d = |waddr_b_d;

    cnt_d = '0;
    if (bus.mul_valid_i && !mul_rdy)
      cnt_d = starved ? LIMIT : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      waddr_a_q <= '0;
      wdata_a_q <= '0;
      we_a_q    <= 1'b0;
      waddr_b_q <= '0;
      wdata_b_q <= '0;
      we_b_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      waddr_a_q <= waddr_a_d;
      wdata_a_q <= wdata_a_d;
      we_a_q    <= we_a_d;
      waddr_b_q <= waddr_b_d;
      wdata_b_q <= wdata_b_d;
      we_b_q    <= we_b_d;
    end
  end

  // Outputs are masked during reset so a write registered just before rst never shows.
  assign bus.alu_ready_o   = alu_rdy;
  assign bus.mul_ready_o   = mul_rdy;
  assign bus.lsu_ready_o   = lsu_rdy;
  assign bus.we_a_o        = we_a_q && !rst;
  assign bus.waddr_a_o     = rst ? '0 : waddr_a_q;
  assign bus.wdata_a_o     = rst ? '0 : wdata_a_q;
  assign bus.we_b_o        = we_b_q && !rst;
  assign bus.waddr_b_o     = rst ? '0 : waddr_b_q;
  assign bus.wdata_b_o     = rst ? '0 : wdata_b_q;
  assign bus.mul_starved_o = starved && !rst;

endmodule

// File: doc/riscv_wb_arbiter.md
RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 5: register address width.
REQ-002 Parameter DATA_WIDTH, default 32: register data width.
REQ-003 Parameter STARVE_LIMIT, default 3: consecutive MUL stall cycles before MUL gains priority over ALU.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 alu_valid_i / mul_valid_i / lsu_valid_i  input  1 each  producer result valid.
REQ-007 alu_waddr_i / mul_waddr_i / lsu_waddr_i  input  ADDR_WIDTH each  destination register.
REQ-008 alu_wdata_i / mul_wdata_i / lsu_wdata_i  input  DATA_WIDTH each  result data.
REQ-009 alu_ready_o / mul_ready_o / lsu_ready_o  output  1 each  result accepted this cycle when valid & ready.
REQ-010 waddr_a_o, wdata_a_o, we_a_o  output  ADDR_WIDTH, DATA_WIDTH, 1  register-file write port A.
REQ-011 waddr_b_o, wdata_b_o, we_b_o  output  ADDR_WIDTH, DATA_WIDTH, 1  register-file write port B.
REQ-012 mul_starved_o  output  1  high while the starvation counter is at or above STARVE_LIMIT.

Function
REQ-013 Write-port outputs SHALL be registered: a handshake in cycle N drives the write port in cycle N+1, held exactly one cycle.
REQ-014 LSU SHALL only use port B; lsu_ready_o SHALL equal 1 whenever not in reset.
REQ-015 In normal mode, ALU SHALL use port A; alu_ready_o = 1 unless REQ-017 or REQ-018 stalls it.
REQ-016 MUL SHALL take port A if alu_valid_i=0; else port B if lsu_valid_i=0; else mul_ready_o=0.
REQ-017 Starved mode (mul_starved_o=1, mul_valid_i=1): MUL SHALL take port A; ALU SHALL take port B if lsu_valid_i=0, else alu_ready_o=0.
REQ-018 Same-address conflict: if two candidate grants target the same nonzero address, only the higher-priority one (LSU > MUL > ALU) SHALL be granted; the other's ready SHALL be 0.
REQ-019 Writes to address 0 SHALL be accepted (ready=1 per rules above) but SHALL produce we=0 on the port they would use; they SHALL not trigger REQ-018.
REQ-020 When a port is unused, its we SHALL be 0; its waddr/wdata SHALL hold the last value.
REQ-021 Starvation counter SHALL increment (saturating at STARVE_LIMIT) each cycle mul_valid_i=1 and mul_ready_o=0.
REQ-022 Counter SHALL clear on any cycle where MUL handshakes or mul_valid_i=0.
REQ-023 mul_ready_o SHALL never be asserted when mul_valid_i=0 blocks nothing: readies SHALL be independent of the same producer's own valid (no combinational loop on valid->ready of same source).
REQ-024 At most one write per port per cycle; we_a_o and we_b_o SHALL never both be 1 with equal nonzero waddr.
REQ-025 Ready outputs SHALL be combinational from valid/address inputs and counter state only.

Reset
REQ-026 While rst=1: all ready outputs 0, we_a_o=we_b_o=0, waddr/wdata outputs 0, counter 0, mul_starved_o=0.
REQ-027 A handshake in the cycle rst asserts SHALL be discarded; first legal handshake is the first cycle with rst=0.
REQ-028 Reset mid-operation SHALL suppress any write registered in the previous cycle from reaching the next cycle's outputs.

Verification
REQ-029 ALU x5=0x11 and LSU x6=0x22 same cycle -> next cycle we_a_o=1 (x5,0x11), we_b_o=1 (x6,0x22), all readies 1.
REQ-030 ALU x7, MUL x8, LSU x9 valid for 4 cycles -> mul_ready_o=0 for 3 cycles, mul_starved_o=1 in cycle 4, MUL granted port A, alu_ready_o=0, counter clears next cycle.
REQ-031 MUL x3=0xAA, LSU x3=0xBB, ALU idle -> LSU granted, mul_ready_o=0; next cycle we_b_o=1 (x3,0xBB), we_a_o=0; MUL granted the following cycle.
REQ-032 ALU writes x0=0xFFFF -> alu_ready_o=1, next cycle we_a_o=0.
REQ-033 rst asserted during ALU x4 handshake -> no write appears; outputs all 0 one cycle after rst; normal operation on first cycle after rst deasserts.
